// File: rtl/ibex_pmp_csr_regs_if.sv
// CSR request/response bundle between the core CSR file (master) and the PMP register bank (slave).
interface ibex_pmp_csr_regs_if;
    logic        csr_req_i;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic        csr_rvalid_o;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        csr_wr_ignored_o;

    modport master (
        output csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
        input  csr_rvalid_o, csr_rdata_o, csr_illegal_o, csr_wr_ignored_o
    );

    modport slave (
        input  csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
        output csr_rvalid_o, csr_rdata_o, csr_illegal_o, csr_wr_ignored_o
    );
endinterface

// File: rtl/ibex_pmp_csr_regs.sv
// PMP CSR bank: pmpcfg0-3, pmpaddr0-15, mseccfg(h) with WARL/lock rules and registered read port.
// Optional rule-locking bypass (mseccfg.RLB) is enabled by defining IBEX_PMP_RLB_EN.
module ibex_pmp_csr_regs #(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    ibex_pmp_csr_regs_if.slave            csr,
    output logic [PMPNumRegions*6-1:0]    csr_pmp_cfg_o,
    output logic [PMPNumRegions*34-1:0]   csr_pmp_addr_o,
    output logic [2:0]                    csr_pmp_mseccfg_o
);

    localparam int N = int'(PMPNumRegions);
    localparam int G = int'(PMPGranularity);

    localparam logic [1:0] A_OFF   = 2'b00;
    localparam logic [1:0] A_TOR   = 2'b01;
    localparam logic [1:0] A_NA4   = 2'b10;
    localparam logic [1:0] A_NAPOT = 2'b11;

    function automatic logic [31:0] low_mask(input int n);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = (i < n);
        return m;
    endfunction

    localparam logic [31:0] NapotOnes = low_mask(G - 1);
    localparam logic [31:0] OffZeros  = low_mask(G);

    function automatic logic [7:0] cfg_to_byte(input logic [5:0] c);
        return {c[5], 2'b00, c[4:0]};
    endfunction

    // NA4 cannot be expressed once the granule exceeds 4 bytes, so it legalises to OFF.
    function automatic logic [5:0] byte_to_cfg(input logic [7:0] b);
        logic [1:0] a;
        a = b[4:3];
        if (a == A_NA4 && G > 0) a = A_OFF;
        return {b[7], a, b[2:0]};
    endfunction

    function automatic logic [31:0] addr_view(input logic [31:0] a, input logic [1:0] mode);
        logic [31:0] v;
        v = a;
        if (mode == A_NAPOT)  v = v | NapotOnes;
        else if (!mode[1])    v = v & ~OffZeros;
        return v;
    endfunction

    logic [5:0]  cfg_q  [N];
    logic [5:0]  cfg_d  [N];
    logic [31:0] addr_q [N];
    logic [31:0] addr_d [N];
    logic        mml_q, mmwp_q, rlb_q;
    logic        mml_d, mmwp_d, rlb_d;

    logic        rvalid_p1;
    logic [31:0] rdata_p1;
    logic        illegal_p1;
    logic        ignored_p1;

    logic        is_cfg, is_addr, is_msec, is_msech, legal;
    logic        wr, rd;
    logic        bypass;
    logic        ignore;
    logic [7:0]  wbyte;
    logic [31:0] rdata_d;
    logic [N-1:0] lock_vec;
    logic [N:0]   tor_lock;

    assign is_cfg   = (csr.csr_addr_i[11:2] == 10'h0E8);
    assign is_addr  = (csr.csr_addr_i[11:4] == 8'h3B);
    assign is_msec  = (csr.csr_addr_i == 12'h747);
    assign is_msech = (csr.csr_addr_i == 12'h757);
    assign legal    = is_cfg | is_addr | is_msec | is_msech;
    assign wr       = csr.csr_req_i & csr.csr_we_i;
    assign rd       = csr.csr_req_i & ~csr.csr_we_i;

`ifdef IBEX_PMP_RLB_EN
    assign bypass = rlb_q;
`else
    assign bypass = 1'b0;
`endif

    // tor_lock has a spare top bit so entry N-1 can look at "entry N" safely.
    always_comb begin
        lock_vec = '0;
        tor_lock = '0;
        for (int e = 0; e < N; e++) begin
            lock_vec[e] = cfg_q[e][5];
            tor_lock[e] = cfg_q[e][5] && (cfg_q[e][4:3] == A_TOR);
        end
    end

    always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        mml_d  = mml_q;
        mmwp_d = mmwp_q;
        rlb_d  = rlb_q;
        ignore = 1'b0;
        wbyte  = '0;
        if (wr) begin
            if (is_cfg) begin
                for (int e = 0; e < N; e++) begin
                    if ((e / 4) == int'(csr.csr_addr_i[1:0])) begin
                        wbyte = csr.csr_wdata_i[8*(e%4) +: 8];
                        if ((cfg_q[e][5] && !bypass) || (wbyte[1] && !wbyte[0] && !mml_q))
                            ignore = 1'b1;
                        else
                            cfg_d[e] = byte_to_cfg(wbyte);
                    end
                end
            end
            if (is_addr) begin
                for (int e = 0; e < N; e++) begin
                    if (int'(csr.csr_addr_i[3:0]) == e) begin
                        if (!bypass && (lock_vec[e] || tor_lock[e+1]))
                            ignore = 1'b1;
                        else
                            addr_d[e] = csr.csr_wdata_i;
                    end
                end
            end
            if (is_msec) begin
                mml_d  = mml_q  | csr.csr_wdata_i[0];
                mmwp_d = mmwp_q | csr.csr_wdata_i[1];
`ifdef IBEX_PMP_RLB_EN
                if (csr.csr_wdata_i[2]) begin
                    if (!rlb_q && (|lock_vec)) ignore = 1'b1;
                    else                       rlb_d  = 1'b1;
                end else begin
                    rlb_d = 1'b0;
                end
`else
                if (csr.csr_wdata_i[2]) ignore = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        if (is_cfg) begin
            for (int e = 0; e < N; e++) begin
                if ((e / 4) == int'(csr.csr_addr_i[1:0]))
                    rdata_d[8*(e%4) +: 8] = cfg_to_byte(cfg_q[e]);
            end
        end
        if (is_addr) begin
            for (int e = 0; e < N; e++) begin
                if (int'(csr.csr_addr_i[3:0]) == e)
                    rdata_d = addr_view(addr_q[e], cfg_q[e][4:3]);
            end
        end
        if (is_msec) rdata_d = {29'd0, rlb_q, mmwp_q, mml_q};
    end

    // p0 -> p1: state update and registered response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < N; e++) begin
                cfg_q[e]  <= '0;
                addr_q[e] <= '0;
            end
            mml_q      <= 1'b0;
            mmwp_q     <= 1'b0;
            rlb_q      <= 1'b0;
            rvalid_p1  <= 1'b0;
            rdata_p1   <= '0;
            illegal_p1 <= 1'b0;
            ignored_p1 <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            addr_q     <= addr_d;
            mml_q      <= mml_d;
            mmwp_q     <= mmwp_d;
            rlb_q      <= rlb_d;
            rvalid_p1  <= rd;
            rdata_p1   <= rd ? rdata_d : '0;
            illegal_p1 <= csr.csr_req_i & ~legal;
            ignored_p1 <= wr & ignore;
        end
    end

    assign csr.csr_rvalid_o     = rvalid_p1;
    assign csr.csr_rdata_o      = rdata_p1;
    assign csr.csr_illegal_o    = illegal_p1;
    assign csr.csr_wr_ignored_o = ignored_p1;

    always_comb begin
        csr_pmp_cfg_o  = '0;
        csr_pmp_addr_o = '0;
        for (int e = 0; e < N; e++) begin
            csr_pmp_cfg_o[(N-1-e)*6 +: 6]   = cfg_q[e];
            csr_pmp_addr_o[(N-1-e)*34 +: 34] = {addr_q[e], 2'b00};
        end
    end

    assign csr_pmp_mseccfg_o = {rlb_q, mmwp_q, mml_q};

endmodule

// File: tb/tb_ibex_pmp_csr_regs.sv
// Scoreboard bench for ibex_pmp_csr_regs: one G=0 and one G=3 instance driven with directed vectors.
module tb_ibex_pmp_csr_regs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ibex_pmp_csr_regs_if ifa ();
    ibex_pmp_csr_regs_if ifb ();

    logic [23:0]  cfg_a, cfg_b;
    logic [135:0] addr_a, addr_b;
    logic [2:0]   ms_a, ms_b;

    ibex_pmp_csr_regs #(.PMPGranularity(0), .PMPNumRegions(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .csr(ifa),
        .csr_pmp_cfg_o(cfg_a), .csr_pmp_addr_o(addr_a), .csr_pmp_mseccfg_o(ms_a)
    );

    ibex_pmp_csr_regs #(.PMPGranularity(3), .PMPNumRegions(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .csr(ifb),
        .csr_pmp_cfg_o(cfg_b), .csr_pmp_addr_o(addr_b), .csr_pmp_mseccfg_o(ms_b)
    );

    typedef struct packed {
        logic        rd;
        logic [31:0] rdata;
        logic        ill;
        logic        ign;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string nm, input logic [135:0] act, input logic [135:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp_v);
        end
    endfunction

    function automatic void chk_resp(input string nm, input exp_t e, input logic rv,
                                     input logic [31:0] rdv, input logic il, input logic ig);
        checks++;
        if (rv !== e.rd || il !== e.ill || ig !== e.ign || (e.rd && rdv !== e.rdata)) begin
            failures++;
            $display("FAIL %s got rvalid=%b rdata=%h illegal=%b ignored=%b want rvalid=%b rdata=%h illegal=%b ignored=%b",
                     nm, rv, rdv, il, ig, e.rd, e.rdata, e.ill, e.ign);
        end
    endfunction

    task automatic monitor(input int sel);
        logic s;
        exp_t e;
        logic rv, il, ig;
        logic [31:0] rdv;
        forever begin
            @(posedge clk);
            s = ((sel == 0) ? ifa.csr_req_i : ifb.csr_req_i) && !rst;
            @(negedge clk);
            rv  = (sel == 0) ? ifa.csr_rvalid_o     : ifb.csr_rvalid_o;
            rdv = (sel == 0) ? ifa.csr_rdata_o      : ifb.csr_rdata_o;
            il  = (sel == 0) ? ifa.csr_illegal_o    : ifb.csr_illegal_o;
            ig  = (sel == 0) ? ifa.csr_wr_ignored_o : ifb.csr_wr_ignored_o;
            if (s) begin
                if ((sel == 0 && qa.size() == 0) || (sel == 1 && qb.size() == 0)) begin
                    checks++;
                    failures++;
                    $display("FAIL resp%0d response with empty scoreboard", sel);
                end else begin
                    e = (sel == 0) ? qa.pop_front() : qb.pop_front();
                    chk_resp((sel == 0) ? "resp_a" : "resp_b", e, rv, rdv, il, ig);
                end
            end else if (!rst) begin
                chk((sel == 0) ? "idle_a" : "idle_b", 136'({rv, il, ig}), 136'(0));
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic acc(input int sel, input logic we, input logic [11:0] a, input logic [31:0] d,
                       input logic ill, input logic ign, input logic [31:0] rdv);
        exp_t e;
        e.rd = !we; e.rdata = rdv; e.ill = ill; e.ign = ign;
        if (sel == 0) begin
            qa.push_back(e);
            ifa.csr_req_i = 1'b1; ifa.csr_we_i = we; ifa.csr_addr_i = a; ifa.csr_wdata_i = d;
        end else begin
            qb.push_back(e);
            ifb.csr_req_i = 1'b1; ifb.csr_we_i = we; ifb.csr_addr_i = a; ifb.csr_wdata_i = d;
        end
        @(posedge clk);
        #1;
        ifa.csr_req_i = 1'b0; ifa.csr_we_i = 1'b0;
        ifb.csr_req_i = 1'b0; ifb.csr_we_i = 1'b0;
    endtask

    task automatic wr(input int sel, input logic [11:0] a, input logic [31:0] d, input logic ign);
        acc(sel, 1'b1, a, d, 1'b0, ign, 32'h0);
    endtask

    task automatic rd(input int sel, input logic [11:0] a, input logic [31:0] v);
        acc(sel, 1'b0, a, 32'h0, 1'b0, 1'b0, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.csr_req_i = 1'b0; ifa.csr_we_i = 1'b0; ifa.csr_addr_i = '0; ifa.csr_wdata_i = '0;
        ifb.csr_req_i = 1'b0; ifb.csr_we_i = 1'b0; ifb.csr_addr_i = '0; ifb.csr_wdata_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_cfg_a",  136'(cfg_a),  136'(0));
        chk("rst_addr_a", addr_a,       136'(0));
        chk("rst_msec_a", 136'(ms_a),   136'(0));
        rd(0, 12'h3A0, 32'h0);
        rd(0, 12'h3B0, 32'h0);
        rd(0, 12'h747, 32'h0);

        // Locked TOR entry 1
        wr(0, 12'h3B1, 32'h2000_0000, 1'b0);
        wr(0, 12'h3A0, 32'h0000_8F00, 1'b0);
        chk("cfg_e1",  136'(cfg_a), 136'(24'h02F000));
        chk("addr_e1", 136'(addr_a[101:68]), 136'(34'h0_8000_0000));
        wr(0, 12'h3B1, 32'h0000_0001, 1'b1);
        rd(0, 12'h3B1, 32'h2000_0000);
        wr(0, 12'h3B0, 32'h0000_0005, 1'b1);
        rd(0, 12'h3B0, 32'h0);
        rd(0, 12'h3A0, 32'h0000_8F00);

        // W-only byte with MML=0, unimplemented entries
        wr(0, 12'h3A0, 32'h0000_0002, 1'b1);
        rd(0, 12'h3A0, 32'h0000_8F00);
        wr(0, 12'h3A1, 32'h0000_1000, 1'b0);
        rd(0, 12'h3A1, 32'h0);
        rd(0, 12'h3B5, 32'h0);

        // mseccfg sticky bits and RLB refusal with a lock present
        wr(0, 12'h747, 32'h3, 1'b0);
        wr(0, 12'h747, 32'h0, 1'b0);
        rd(0, 12'h747, 32'h3);
        wr(0, 12'h747, 32'h4, 1'b1);
        rd(0, 12'h747, 32'h3);
        chk("msec_a", 136'(ms_a), 136'(3'b011));
        wr(0, 12'h3A0, 32'h0000_8F02, 1'b1);
        rd(0, 12'h3A0, 32'h0000_8F02);

        // Illegal and hardwired CSRs, back-to-back write/read
        acc(0, 1'b0, 12'h3C5, 32'h0, 1'b1, 1'b0, 32'h0);
        acc(0, 1'b1, 12'h3C5, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        rd(0, 12'h757, 32'h0);
        wr(0, 12'h757, 32'hFFFF_FFFF, 1'b0);
        rd(0, 12'h747, 32'h3);
        wr(0, 12'h3B2, 32'h0000_ABCD, 1'b0);
        rd(0, 12'h3B2, 32'h0000_ABCD);
        chk("cfg_a_final", 136'(cfg_a), 136'(24'h0AF000));

        // G=3 read view and NA4 legalisation
        wr(1, 12'h3A0, 32'h0000_0018, 1'b0);
        wr(1, 12'h3B0, 32'h0, 1'b0);
        rd(1, 12'h3B0, 32'h3);
        wr(1, 12'h3B0, 32'h5, 1'b0);
        rd(1, 12'h3B0, 32'h7);
        wr(1, 12'h3A0, 32'h0000_0008, 1'b0);
        rd(1, 12'h3B0, 32'h0);
        chk("addr_b_e0_tor", 136'(addr_b[135:102]), 136'(34'h14));
        wr(1, 12'h3B0, 32'h0, 1'b0);
        rd(1, 12'h3B0, 32'h0);
        chk("addr_b_e0_zero", 136'(addr_b[135:102]), 136'(0));
        wr(1, 12'h3A0, 32'h0000_0010, 1'b0);
        rd(1, 12'h3A0, 32'h0);
        wr(1, 12'h3A0, 32'h0000_0002, 1'b1);
        rd(1, 12'h3A0, 32'h0);

`ifdef IBEX_PMP_RLB_EN
        wr(1, 12'h747, 32'h4, 1'b0);
        rd(1, 12'h747, 32'h4);
        chk("msec_b_rlb", 136'(ms_b), 136'(3'b100));
        wr(1, 12'h3A0, 32'h0000_0080, 1'b0);
        wr(1, 12'h3A0, 32'h0000_0083, 1'b0);
        rd(1, 12'h3A0, 32'h0000_0083);
        wr(1, 12'h747, 32'h0, 1'b0);
        rd(1, 12'h747, 32'h0);
        wr(1, 12'h747, 32'h4, 1'b1);
        rd(1, 12'h747, 32'h0);
`else
        wr(1, 12'h747, 32'h4, 1'b1);
        rd(1, 12'h747, 32'h0);
        chk("msec_b_norlb", 136'(ms_b), 136'(0));
        wr(1, 12'h3A0, 32'h0000_0080, 1'b0);
        wr(1, 12'h3A0, 32'h0000_0083, 1'b1);
        rd(1, 12'h3A0, 32'h0000_0080);
`endif

        // Reset asserted in the middle of a read
        repeat (2) begin @(posedge clk); #1; end
        ifa.csr_req_i = 1'b1; ifa.csr_we_i = 1'b0; ifa.csr_addr_i = 12'h3B2;
        #3 rst = 1'b1;
        @(posedge clk);
        #1 ifa.csr_req_i = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", 136'(ifa.csr_rvalid_o), 136'(0));
        chk("rst2_cfg_a",  136'(cfg_a), 136'(0));
        chk("rst2_addr_a", addr_a,      136'(0));
        chk("rst2_cfg_b",  136'(cfg_b), 136'(0));
        chk("rst2_addr_b", addr_b,      136'(0));
        chk("rst2_msec",   136'({ms_a, ms_b}), 136'(0));
        rd(0, 12'h3B2, 32'h0);
        rd(0, 12'h747, 32'h0);

        repeat (3) @(posedge clk);
        chk("scoreboard_a_drained", 136'(qa.size()), 136'(0));
        chk("scoreboard_b_drained", 136'(qb.size()), 136'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
